// File: rtl/lcd_reader.sv
// Timed read master for the HD44780 16x2 LCD bus: one status or data read per request.
// Optional LCD_READER_POLL_EN adds busy-flag polling (i_poll / o_timeout) bounded by POLL_MAX.
module lcd_reader #(
  parameter int T_AS_CYC = 3,
  parameter int T_EH_CYC = 25,
  parameter int T_H_CYC  = 2,
  parameter int T_EL_CYC = 25
`ifdef LCD_READER_POLL_EN
  ,
  parameter int POLL_MAX = 1000
`endif
) (
  input  logic       clock_50,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_rs,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_busy_flag,
  output logic [6:0] o_addr,
  output logic       o_bus_busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [7:0] i_lcd_data
`ifdef LCD_READER_POLL_EN
  ,
  input  logic       i_poll,
  output logic       o_timeout
`endif
);

  localparam int DATA_W = 8;
  localparam int T_MAX01 = (T_AS_CYC > T_EH_CYC) ? T_AS_CYC : T_EH_CYC;
  localparam int T_MAX23 = (T_H_CYC > T_EL_CYC) ? T_H_CYC : T_EL_CYC;
  localparam int T_MAX = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
  localparam int CNT_W = $clog2(T_MAX + 1);

  if (T_AS_CYC < 1 || T_EH_CYC < 1 || T_H_CYC < 1 || T_EL_CYC < 1) begin : g_bad_timing
    $error("lcd_reader: every T_*_CYC parameter must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, EN_LO, DONE} state_t;

  state_t              state_p0, state_nxt;
  logic [CNT_W-1:0]    cnt_p0, cnt_nxt;
  logic                rs_p0, rs_nxt;
  logic                sample_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                last;
  logic                drive_bus;

`ifdef LCD_READER_POLL_EN
  localparam int PC_W = $clog2(POLL_MAX + 1);

  if (POLL_MAX < 1) begin : g_bad_poll
    $error("lcd_reader: POLL_MAX must be at least 1");
  end

  logic                poll_p0, poll_nxt;
  logic [PC_W-1:0]     pcnt_p0, pcnt_nxt;
`endif

  function automatic logic [CNT_W-1:0] load_cnt(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

  assign last      = (cnt_p0 == '0);
  assign drive_bus = (state_p0 == SETUP) || (state_p0 == EN_HI) || (state_p0 == HOLD);

  // Stage p0: state sequencing and per-state timing
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    rs_nxt    = rs_p0;
`ifdef LCD_READER_POLL_EN
    poll_nxt  = poll_p0;
    pcnt_nxt  = pcnt_p0;
`endif
    if ((state_p0 inside {SETUP, EN_HI, HOLD, EN_LO}) && !last)
      cnt_nxt = cnt_p0 - CNT_W'(1);
    case (state_p0)
      IDLE: begin
        if (i_req && o_ready) begin
          state_nxt = SETUP;
          cnt_nxt   = load_cnt(T_AS_CYC);
          rs_nxt    = i_rs;
`ifdef LCD_READER_POLL_EN
          poll_nxt  = i_poll && !i_rs;
          pcnt_nxt  = '0;
`endif
        end
      end
      SETUP: if (last) begin
        state_nxt = EN_HI;
        cnt_nxt   = load_cnt(T_EH_CYC);
      end
      EN_HI: if (last) begin
        state_nxt = HOLD;
        cnt_nxt   = load_cnt(T_H_CYC);
      end
      HOLD: if (last) begin
        state_nxt = EN_LO;
        cnt_nxt   = load_cnt(T_EL_CYC);
      end
      EN_LO: if (last) begin
`ifdef LCD_READER_POLL_EN
        // Controller still busy: go round again unless the read budget is spent.
        if (poll_p0 && data_p1[DATA_W-1] && (pcnt_p0 != PC_W'(POLL_MAX - 1))) begin
          state_nxt = SETUP;
          cnt_nxt   = load_cnt(T_AS_CYC);
          pcnt_nxt  = pcnt_p0 + PC_W'(1);
        end else begin
          state_nxt = DONE;
        end
`else
        state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered pin/handshake decode of the current state, result capture
  always_ff @(posedge clock_50) begin
    if (i_rst) begin
      state_p0    <= IDLE;
      cnt_p0      <= '0;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_bus_busy  <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
      lcd_en      <= 1'b0;
      sample_p1   <= 1'b0;
      o_data      <= '0;
      o_busy_flag <= 1'b0;
      o_addr      <= '0;
`ifdef LCD_READER_POLL_EN
      poll_p0     <= 1'b0;
      pcnt_p0     <= '0;
      o_timeout   <= 1'b0;
`endif
    end else begin
      state_p0   <= state_nxt;
      cnt_p0     <= cnt_nxt;
      o_ready    <= (state_p0 == IDLE);
      o_valid    <= (state_p0 == DONE);
      o_bus_busy <= (state_p0 != IDLE) && (state_p0 != DONE);
      lcd_rw     <= drive_bus;
      lcd_rs     <= drive_bus && rs_p0;
      lcd_en     <= (state_p0 == EN_HI);
      sample_p1  <= (state_p0 == EN_HI) && last;
`ifdef LCD_READER_POLL_EN
      poll_p0    <= poll_nxt;
      pcnt_p0    <= pcnt_nxt;
`endif
      if (state_p0 == DONE) begin
        o_data <= data_p1;
        if (!rs_p0) begin
          o_busy_flag <= data_p1[DATA_W-1];
          o_addr      <= data_p1[DATA_W-2:0];
        end
`ifdef LCD_READER_POLL_EN
        o_timeout <= poll_p0 && data_p1[DATA_W-1];
`endif
      end
    end
  end

  // Stage p1 data: bus byte is taken at the edge that ends the last EN-high cycle
  always_ff @(posedge clock_50) begin
    rs_p0 <= rs_nxt;
    if (sample_p1)
      data_p1 <= i_lcd_data;
  end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side master for the HD44780-compatible 16x2 character LCD bus on the DE2 board.
- Performs one timed read cycle per request (RW=1) and returns either:
  - the status byte (busy flag + address counter, RS=0), or
  - a DDRAM/CGRAM data byte (RS=1).
- Sits beside the existing LCD write path. Top-level arbitration uses o_bus_busy to gate the shared RS/RW/EN pins and to tristate lcd_data while a read is in flight.

Parameters:
- T_AS_CYC, 3, clock cycles RS/RW setup before EN rises (60 ns at 50 MHz, spec min 40 ns)
- T_EH_CYC, 25, clock cycles EN high (500 ns, spec min 450 ns); data sampled on last cycle
- T_H_CYC, 2, clock cycles RS/RW hold after EN falls (40 ns)
- T_EL_CYC, 25, clock cycles EN low recovery before next access (total cycle 1100 ns, spec min 1000 ns)
- POLL_MAX, 1000, max status reads per poll request (optional feature only)

Ports:
- clock_50  in  1  system clock, 50 MHz
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  1  read request; accepted only when o_ready=1
- i_rs  in  1  register select for the request: 0=status, 1=data
- o_ready  out  1  high in IDLE; request may be issued
- o_valid  out  1  one-cycle pulse; result outputs valid
- o_data  out  8  raw byte read
- o_busy_flag  out  1  bit 7 of last status read
- o_addr  out  7  bits 6:0 of last status read
- o_bus_busy  out  1  high from acceptance until recovery done; top level tristates lcd_data and selects this block's RS/RW/EN
- lcd_rs  out  1  LCD RS pin
- lcd_rw  out  1  LCD RW pin
- lcd_en  out  1  LCD EN pin
- i_lcd_data  in  8  LCD data pins, input side

Behaviour:
- Clock and reset: single clock clock_50. i_rst is synchronous, active-high, and overrides everything.
- Reset values: state IDLE, o_ready=1, o_valid=0, o_data=0, o_busy_flag=0, o_addr=0, o_bus_busy=0, lcd_rs=0, lcd_rw=0, lcd_en=0.
- States: IDLE, SETUP, EN_HI, HOLD, EN_LO, DONE. A single down-counter, sized for the largest T_*_CYC, times every state.
- IDLE:
  - i_req=1 at edge k latches i_rs and moves to SETUP.
  - o_ready=0 and o_bus_busy=1 from cycle k+1.
  - i_req while not IDLE is ignored (not queued).
- SETUP: lcd_rw=1, lcd_rs=latched rs, lcd_en=0; lasts T_AS_CYC cycles.
- EN_HI: lcd_en=1; lasts T_EH_CYC cycles. i_lcd_data is registered on the last EN_HI cycle.
- HOLD: lcd_en=0, RS/RW unchanged; lasts T_H_CYC cycles.
- EN_LO: lcd_rw=0, lcd_rs=0, lcd_en=0, o_bus_busy still 1; lasts T_EL_CYC cycles.
- DONE (one cycle):
  - o_valid=1, o_bus_busy=0; returns to IDLE.
  - o_ready=1 on the following cycle.
- Default latency: request accepted at edge k → o_valid high in cycle k+56. That is 1 + T_AS+T_EH+T_H+T_EL = 1+3+25+2+25.
- Result outputs update at DONE:
  - o_data always takes the sampled byte.
  - If rs=0: o_busy_flag=byte[7] and o_addr=byte[6:0].
  - If rs=1: o_busy_flag and o_addr hold their previous values.
- Back-to-back: i_req held high continuously → accepted again in the first IDLE cycle. The request period is therefore 58 cycles.
- Reset mid-operation (any state) → next edge IDLE with reset values; lcd_en drops immediately; no o_valid.
- lcd_en never high unless lcd_rw=1 and the RS setup time has elapsed. No glitches: all LCD pins are driven from registers.
- Each T_*_CYC must be ≥1; a value of 0 is illegal (elaboration error).

Optional Feature:
- Macro: LCD_READER_POLL_EN.
- Defined:
  - Adds ports i_poll (in, 1) and o_timeout (out, 1, reset 0).
  - A request with i_rs=0 and i_poll=1 repeats status reads (SETUP..EN_LO) while the sampled BF=1, up to POLL_MAX reads.
  - o_valid pulses once, either at the first read with BF=0 (o_timeout=0) or after POLL_MAX reads with BF still 1 (o_timeout=1).
  - o_bus_busy stays 1 across all repeats.
  - i_poll is ignored when i_rs=1.
- Undefined: ports absent; every request performs exactly one read.

Test Plan:
- Reset, then idle 10 cycles → o_ready=1, o_bus_busy=0, all LCD pins 0, o_valid never asserted.
- i_req=1, i_rs=0, i_lcd_data=8'h85 at edge k → o_valid in cycle k+56; o_data=8'h85, o_busy_flag=1, o_addr=7'h05. lcd_en high for exactly 25 cycles, 3 cycles after lcd_rw rose.
- Status read giving 8'h85, then i_rs=1 with i_lcd_data=8'h41 → o_data=8'h41; o_busy_flag=1 and o_addr=7'h05 unchanged; lcd_rs=1 throughout SETUP..HOLD.
- i_req held high for 200 cycles → exactly 3 o_valid pulses, 58 cycles apart. Extra i_req during busy is ignored.
- i_rst asserted during EN_HI → lcd_en=0 next cycle, no o_valid, o_ready=1; a new request then completes normally in 56 cycles.
- (LCD_READER_POLL_EN, POLL_MAX=4) i_poll=1, BF=1 for the first 2 reads then 8'h07:
  - expect 3 EN pulses, one o_valid, o_busy_flag=0, o_timeout=0.
  - With BF stuck at 1: expect 4 pulses, o_timeout=1.
